// File: rtl/sy_pkg.sv
// Shared types and constants for the sy FP rename pipeline.
// Entry phy fields are sized for the largest supported FP register file.
package sy_pkg;

  localparam int FP_ARC_REG_NUM = 32;
  // Upper bound on PHY_REG_WTH (1024 FP physical registers); narrower configs zero-extend.
  localparam int FP_PHY_WTH_MAX = 10;

  typedef struct packed {
    logic [4:0]                arc_rd;
    logic [FP_PHY_WTH_MAX-1:0] phy;
    logic [FP_PHY_WTH_MAX-1:0] old_phy;
  } fp_rtq_entry_t;

endpackage

// File: rtl/sy_ppl_rtq_ring.sv
// Generic circular buffer with push/pop/flush, occupancy count and full/empty.
// Pushes are rejected when full and pops when empty; flush empties the ring and wins over both.
module sy_ppl_rtq_ring
  import sy_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = fp_rtq_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_dat_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/sy_ppl_fp_rtq.sv
// FP rename retire queue: logs each FP dest rename, releases old phys regs at commit (0-cycle),
// and keeps the committed arch map. Rename must stall on rtq_full_o; a flush drops all uncommitted entries.
module sy_ppl_fp_rtq
  import sy_pkg::*;
#(
  parameter int  PHY_REG_NUM = 64,
  parameter int  RTQ_DEPTH   = 16,
  localparam int PHY_REG_WTH = $clog2(PHY_REG_NUM),
  localparam int CNT_W       = $clog2(RTQ_DEPTH) + 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic                                        ren_en_i,
  input  logic [4:0]                                  ren_arc_rdst_idx_i,
  input  logic [PHY_REG_WTH-1:0]                      ren_phy_rdst_idx_i,
  input  logic [PHY_REG_WTH-1:0]                      ren_old_phy_i,
  output logic                                        rtq_full_o,
  output logic                                        rtq_empty_o,
  output logic [CNT_W-1:0]                            rtq_cnt_o,
  input  logic                                        rob_commit_en_i,
  output logic                                        rob_update_afl_en_o,
  output logic [PHY_REG_WTH-1:0]                      rob_update_afl_phy_o,
  output logic [PHY_REG_WTH-1:0]                      rob_update_afl_old_phy_o,
  output logic [FP_ARC_REG_NUM-1:0][PHY_REG_WTH-1:0]  arc_map_o
);

  fp_rtq_entry_t push_dat, head;
  logic          pop;
  logic [FP_ARC_REG_NUM-1:0][PHY_REG_WTH-1:0] arc_map_q, arc_map_d;

  always_comb begin
    push_dat         = '0;
    push_dat.arc_rd  = ren_arc_rdst_idx_i;
    push_dat.phy     = FP_PHY_WTH_MAX'(ren_phy_rdst_idx_i);
    push_dat.old_phy = FP_PHY_WTH_MAX'(ren_old_phy_i);
  end

  sy_ppl_rtq_ring #(
    .DEPTH   (RTQ_DEPTH),
    .entry_t (fp_rtq_entry_t)
  ) u_ring (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (ren_en_i),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (rtq_full_o),
    .empty_o    (rtq_empty_o),
    .cnt_o      (rtq_cnt_o)
  );

  // Flush and commit never coincide, so the release strobe needs no flush qualifier.
  assign pop                      = rob_commit_en_i & ~rtq_empty_o;
  assign rob_update_afl_en_o      = pop;
  assign rob_update_afl_phy_o     = head.phy[PHY_REG_WTH-1:0];
  assign rob_update_afl_old_phy_o = head.old_phy[PHY_REG_WTH-1:0];

  always_comb begin
    arc_map_d = arc_map_q;
    if (pop) arc_map_d[head.arc_rd] = head.phy[PHY_REG_WTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FP_ARC_REG_NUM; i++) arc_map_q[i] <= PHY_REG_WTH'(i);
    end else begin
      arc_map_q <= arc_map_d;
    end
  end

  assign arc_map_o = arc_map_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(ren_en_i && rtq_full_o && !flush_i))
        else $warning("sy_ppl_fp_rtq: rename push while queue full was dropped");
      assert (!(rob_commit_en_i && rtq_empty_o))
        else $warning("sy_ppl_fp_rtq: commit while queue empty was ignored");
      assert (!(flush_i && rob_commit_en_i))
        else $error("sy_ppl_fp_rtq: flush and commit in the same cycle");
    end
  end

endmodule

// File: tb/tb_sy_ppl_fp_rtq.sv
// Bench for sy_ppl_fp_rtq: table-driven vectors plus hand-written fill/wrap, overlap and flush sequences,
// with a queue scoreboard of pushed records checked against each release strobe.
module tb_sy_ppl_fp_rtq;
  import sy_pkg::*;

  localparam int PW = 6;
  localparam int D  = 16;
  localparam int CW = 5;

  logic                clk_i = 1'b0;
  logic                rst_i, flush_i, ren_en_i, rob_commit_en_i;
  logic [4:0]          ren_arc_rdst_idx_i;
  logic [PW-1:0]       ren_phy_rdst_idx_i, ren_old_phy_i;
  logic                rtq_full_o, rtq_empty_o;
  logic [CW-1:0]       rtq_cnt_o;
  logic                rob_update_afl_en_o;
  logic [PW-1:0]       rob_update_afl_phy_o, rob_update_afl_old_phy_o;
  logic [31:0][PW-1:0] arc_map_o;

  sy_ppl_fp_rtq #(.PHY_REG_NUM(64), .RTQ_DEPTH(D)) dut (
    .clk_i                    (clk_i),
    .rst_i                    (rst_i),
    .flush_i                  (flush_i),
    .ren_en_i                 (ren_en_i),
    .ren_arc_rdst_idx_i       (ren_arc_rdst_idx_i),
    .ren_phy_rdst_idx_i       (ren_phy_rdst_idx_i),
    .ren_old_phy_i            (ren_old_phy_i),
    .rtq_full_o               (rtq_full_o),
    .rtq_empty_o              (rtq_empty_o),
    .rtq_cnt_o                (rtq_cnt_o),
    .rob_commit_en_i          (rob_commit_en_i),
    .rob_update_afl_en_o      (rob_update_afl_en_o),
    .rob_update_afl_phy_o     (rob_update_afl_phy_o),
    .rob_update_afl_old_phy_o (rob_update_afl_old_phy_o),
    .arc_map_o                (arc_map_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]    arc;
    logic [PW-1:0] phy;
    logic [PW-1:0] old;
  } rec_t;

  typedef struct {
    bit            push;
    rec_t          r;
    bit            commit;
    bit            exp_en;
    logic [PW-1:0] exp_phy;
    logic [PW-1:0] exp_old;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  rec_t          sb_q[$];
  logic [PW-1:0] map_m [32];
  logic          s_en;
  logic [PW-1:0] s_phy, s_old;
  vec_t          tbl [6];
  rec_t          idle_r = '{5'd0, 6'd0, 6'd0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_map();
    for (int i = 0; i < 32; i++) chk($sformatf("arc_map[%0d]", i), arc_map_o[i], map_m[i]);
  endtask

  // One clock: check registered status, drive, check releases against the scoreboard, update model.
  task automatic cycle(input bit push, input rec_t r, input bit commit, input bit flush);
    bit was_full;
    @(negedge clk_i);
    chk("cnt", rtq_cnt_o, sb_q.size());
    chk("empty", rtq_empty_o, sb_q.size() == 0);
    chk("full", rtq_full_o, sb_q.size() == D);
    was_full           = (sb_q.size() == D);
    ren_en_i           = push;
    ren_arc_rdst_idx_i = r.arc;
    ren_phy_rdst_idx_i = r.phy;
    ren_old_phy_i      = r.old;
    rob_commit_en_i    = commit;
    flush_i            = flush;
    #1;
    s_en  = rob_update_afl_en_o;
    s_phy = rob_update_afl_phy_o;
    s_old = rob_update_afl_old_phy_o;
    chk("afl_en", rob_update_afl_en_o, commit && sb_q.size() != 0);
    if (rob_update_afl_en_o) begin
      if (sb_q.size() == 0) begin
        chk("afl_underflow", 1, 0);
      end else begin
        rec_t h = sb_q.pop_front();
        chk("afl_phy", rob_update_afl_phy_o, h.phy);
        chk("afl_old_phy", rob_update_afl_old_phy_o, h.old);
        map_m[h.arc] = h.phy;
      end
    end
    if (flush) sb_q.delete();
    else if (push && !was_full) sb_q.push_back(r);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; ren_en_i = 1'b0; rob_commit_en_i = 1'b0;
    ren_arc_rdst_idx_i = '0; ren_phy_rdst_idx_i = '0; ren_old_phy_i = '0;
    for (int i = 0; i < 32; i++) map_m[i] = PW'(i);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state, including a commit against the empty queue.
    chk("reset_empty", rtq_empty_o, 1);
    chk("reset_cnt", rtq_cnt_o, 0);
    chk("reset_full", rtq_full_o, 0);
    chk("reset_map5", arc_map_o[5], 5);
    cycle(0, idle_r, 1, 0);
    chk("reset_commit_afl_en", s_en, 0);
    check_map();

    // Single push/commit and back-to-back rename of the same arch register.
    tbl[0] = '{1, '{5'd3, 6'd40, 6'd3},  0, 0, 6'd0,  6'd0};
    tbl[1] = '{0, '{5'd0, 6'd0,  6'd0},  1, 1, 6'd40, 6'd3};
    tbl[2] = '{1, '{5'd7, 6'd33, 6'd7},  0, 0, 6'd0,  6'd0};
    tbl[3] = '{1, '{5'd7, 6'd34, 6'd33}, 0, 0, 6'd0,  6'd0};
    tbl[4] = '{0, '{5'd0, 6'd0,  6'd0},  1, 1, 6'd33, 6'd7};
    tbl[5] = '{0, '{5'd0, 6'd0,  6'd0},  1, 1, 6'd34, 6'd33};
    for (int v = 0; v < 6; v++) begin
      cycle(tbl[v].push, tbl[v].r, tbl[v].commit, 0);
      chk($sformatf("tbl%0d_en", v), s_en, tbl[v].exp_en);
      if (tbl[v].exp_en) begin
        chk($sformatf("tbl%0d_phy", v), s_phy, tbl[v].exp_phy);
        chk($sformatf("tbl%0d_old", v), s_old, tbl[v].exp_old);
      end
    end
    chk("map3_is_40", arc_map_o[3], 40);
    chk("map7_is_34", arc_map_o[7], 34);
    check_map();

    // Fill to full, overflow push, partial drain/refill across the wrap, full drain.
    for (int i = 0; i < D; i++) cycle(1, '{5'(i), 6'(10 + i), 6'(i)}, 0, 0);
    chk("full_after_16", rtq_full_o, 1);
    cycle(1, '{5'd20, 6'd63, 6'd20}, 0, 0);
    chk("cnt_after_drop", rtq_cnt_o, 16);
    for (int i = 0; i < 4; i++) cycle(0, idle_r, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, '{5'(16 + i), 6'(30 + i), 6'(16 + i)}, 0, 0);
    for (int i = 0; i < D; i++) cycle(0, idle_r, 1, 0);
    chk("drained_empty", rtq_empty_o, 1);
    check_map();

    // Simultaneous push and pop at occupancy 5.
    for (int i = 0; i < 5; i++) cycle(1, '{5'(i + 1), 6'(40 + i), 6'(i + 1)}, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, '{5'(i + 8), 6'(45 + i), 6'(i + 8)}, 1, 0);
    chk("overlap_cnt5", rtq_cnt_o, 5);
    for (int i = 0; i < 5; i++) cycle(0, idle_r, 1, 0);
    check_map();

    // Flush after partial commit; push in the following cycle is accepted.
    for (int i = 0; i < 6; i++) cycle(1, '{5'(10 + i), 6'(50 + i), 6'(10 + i)}, 0, 0);
    cycle(0, idle_r, 1, 0);
    cycle(0, idle_r, 1, 0);
    cycle(1, '{5'd25, 6'd62, 6'd25}, 0, 1);
    chk("flush_cnt0", rtq_cnt_o, 0);
    chk("flush_map10", arc_map_o[10], 50);
    chk("flush_map11", arc_map_o[11], 51);
    chk("flush_map12_untouched", arc_map_o[12], map_m[12]);
    cycle(1, '{5'd20, 6'd60, 6'd20}, 0, 0);
    chk("post_flush_cnt1", rtq_cnt_o, 1);
    cycle(0, idle_r, 1, 0);
    chk("post_flush_phy", s_phy, 60);
    chk("post_flush_old", s_old, 20);
    cycle(0, idle_r, 0, 0);
    chk("map20_is_60", arc_map_o[20], 60);
    check_map();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sy_ppl_fp_rtq.md
# sy_ppl_fp_rtq

FP rename retire queue: in-order record of every FP destination rename, drained at ROB commit. It sits between FP rename and the FP free list and produces that list's retire-release interface, `rob_update_afl_*`. It also maintains the committed (architectural) FP map table used for flush recovery.

## Interface
Parameters:
- `PHY_REG_NUM`, default 64: number of FP physical registers; `PHY_REG_WTH = $clog2(PHY_REG_NUM)`.
- `RTQ_DEPTH`, default 16: queue entries; must be a power of 2 and ≥2.

Ports. Clock is `clk_i`; reset is `rst_i`, synchronous and active-high.
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous active-high reset
- `flush_i`  in  1  pipeline flush; discards all uncommitted entries
- `ren_en_i`  in  1  push one rename record
- `ren_arc_rdst_idx_i`  in  5  architectural FP destination
- `ren_phy_rdst_idx_i`  in  PHY_REG_WTH  newly allocated physical register
- `ren_old_phy_i`  in  PHY_REG_WTH  previous speculative mapping of that arch register
- `rtq_full_o`  out  1  no free entry; rename must stall
- `rtq_empty_o`  out  1  no entries
- `rtq_cnt_o`  out  $clog2(RTQ_DEPTH)+1  occupancy
- `rob_commit_en_i`  in  1  ROB head (an FP-dest instruction) commits this cycle
- `rob_update_afl_en_o`  out  1  release strobe to the free list
- `rob_update_afl_phy_o`  out  PHY_REG_WTH  committed new physical register
- `rob_update_afl_old_phy_o`  out  PHY_REG_WTH  physical register to release
- `arc_map_o`  out  32×PHY_REG_WTH  committed arch→phys map

## Operation
- **Storage:** circular buffer of `RTQ_DEPTH` entries of `{arc_rd, phy, old_phy}`, with head pointer `rd_ptr`, tail pointer `wr_ptr` and an occupancy count.
  - Pointers are `$clog2(RTQ_DEPTH)` bits and wrap naturally.
  - `full` = count==`RTQ_DEPTH`; `empty` = count==0.
- **Push:** `ren_en_i & ~full` writes the entry at `wr_ptr` and increments `wr_ptr`. A push while full is dropped and fires a simulation assertion. A push in the same cycle as a pop is still rejected when full; `full` depends only on count.
- **Pop:** `pop = rob_commit_en_i & ~empty`. A commit while empty is ignored and fires an assertion.
- **Release outputs** are combinational from the head entry:
  - `rob_update_afl_en_o = pop`
  - `rob_update_afl_phy_o = head.phy`
  - `rob_update_afl_old_phy_o = head.old_phy`
- **Commit side effects:** on pop, `arc_map[head.arc_rd] <= head.phy` and `rd_ptr` increments.
- **Simultaneous push and pop** (not full, not empty): both happen and count is unchanged.
- **Flush:** `rd_ptr`, `wr_ptr` and count are cleared to 0; `arc_map` is untouched. `ren_en_i` in the flush cycle is dropped.
- **Flush/commit exclusivity:** `flush_i` and `rob_commit_en_i` are mutually exclusive by ROB protocol, enforced by assertion. The free list restores from its architectural copy on flush, so a same-cycle release would be lost.
- **Reset:** pointers and count are 0, and `arc_map[i] = i` for i in 0..31.
  - Output reset values: `rtq_full_o`=0, `rtq_empty_o`=1, `rtq_cnt_o`=0, `rob_update_afl_en_o`=0.
  - Entry storage is not reset.
- **Entries are write-once and read-once**; there is no bypass of the entry being pushed into the head in the same cycle.

## Timing
- A push at cycle N is poppable from cycle N+1; `rtq_empty_o` deasserts in N+1.
- Commit-to-release latency is 0 cycles: the release strobe is in the same cycle as `rob_commit_en_i`. `arc_map_o` reflects the commit from N+1.
- `rtq_full_o`, `rtq_empty_o` and `rtq_cnt_o` are registered-state derived and valid from the cycle after the causing edge.
- After a flush at N, the queue is empty in N+1, and a push in N+1 is accepted.
- Throughput: one push and one pop per cycle.

## Structure
- `sy_pkg` holds:
  - `fp_rtq_entry_t` (`arc_rd[4:0]`, `phy`, `old_phy`)
  - `FP_ARC_REG_NUM = 32`
- One sub-module, `sy_ppl_rtq_ring`: a generic parameterised ring buffer (push/pop/flush, count, full/empty) carrying `fp_rtq_entry_t`.
- The arch map and the release logic stay in the top level.

## Test plan
- **Reset:** after reset, `rtq_empty_o`=1, `rtq_cnt_o`=0, `arc_map_o[5]`=5, and `rob_update_afl_en_o`=0 even with `rob_commit_en_i`=1.
- **Single push/commit:** push {arc 3, phy 40, old 3}, then commit the next cycle. Expect afl_en=1, phy=40, old_phy=3 in that cycle, and `arc_map_o[3]`=40 one cycle later.
- **Fill and wrap:** push 16 entries, so `rtq_full_o`=1. A 17th push is dropped and count stays 16. Pop 4, push 4, then drain all 16; release order must match push order across the pointer wrap.
- **Simultaneous push+pop:** with count 5, assert both for 10 cycles. Count stays 5 and the releases are in FIFO order.
- **Flush:** push 6 and commit 2, then flush. Count=0 and `arc_map_o` holds only the 2 committed updates. A push in the next cycle is accepted and its later release is correct.
- **Back-to-back same arch reg:** push {arc 7, phy 33, old 7} then {arc 7, phy 34, old 33}, and commit both. The releases are old_phy 7 then 33, and the final `arc_map_o[7]`=34.
